// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the RV32I datapath/memory.
// Latency: none, wires only.
// Backpressure: mem_ready stalls the controller while mem_req is high.
interface multicycle_control_if;
    // Instruction fields and datapath status
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        mem_ready;

    // Control outputs
    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [3:0]  alu_control;
    logic        illegal;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    // Controller side
    modport master (
        input  opcode, funct3, funct7, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_control, illegal,
               cycle_cnt, instret_cnt
    );

    // Datapath / memory side
    modport slave (
        output opcode, funct3, funct7, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_control, illegal,
               cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing a multicycle RV32I subset datapath; MC_PERF_EN adds perf counters.
// Latency: LW 5, SW 4, ALU 4, branch 3, JAL 4 cycles, plus one per cycle of mem_ready low.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold mem_req and address selects until mem_ready.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master ctl_bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_mem_req;
    logic        w_mem_write;
    logic        w_adr_src;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_reg_write;
    logic [1:0]  w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [1:0]  w_result_src;
    logic [3:0]  w_alu_control;
    logic [3:0]  w_alu_op;
    logic        w_illegal;

    // Only funct7[5] distinguishes SUB from ADD; the other bits carry no meaning here.
    logic        w_unused_funct7;
    assign w_unused_funct7 = ^{ctl_bus.funct7[6], ctl_bus.funct7[4:0]};

    // State register; reset parks the machine in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_state_nxt;
    end

    // ALU operation for EXECR/EXECI; SUB only for register-register with funct7[5].
    always_comb begin
        w_alu_op = ALU_ADD;
        case (ctl_bus.funct3)
            3'b000:  w_alu_op = (r_state == S_EXECR && ctl_bus.funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_op = ALU_SLL;
            3'b010:  w_alu_op = ALU_SLT;
            3'b100:  w_alu_op = ALU_XOR;
            3'b101:  w_alu_op = ALU_SRL;
            3'b110:  w_alu_op = ALU_OR;
            3'b111:  w_alu_op = ALU_AND;
            default: w_alu_op = ALU_ADD;
        endcase
    end

    // Next-state and Moore output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_mem_req     = 1'b0;
        w_mem_write   = 1'b0;
        w_adr_src     = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_reg_write   = 1'b0;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_result_src  = 2'b00;
        w_alu_control = ALU_ADD;
        w_illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                if (ctl_bus.mem_ready) begin
                    w_ir_write  = 1'b1;
                    w_pc_write  = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut for a later branch/jump.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (ctl_bus.opcode)
                    OP_LOAD, OP_STORE: w_state_nxt = S_MEMADR;
                    OP_RTYPE:  w_state_nxt = (ctl_bus.funct3 == 3'b011) ? S_HALT : S_EXECR;
                    OP_ITYPE:  w_state_nxt = (ctl_bus.funct3 == 3'b011) ? S_HALT : S_EXECI;
                    OP_BRANCH: w_state_nxt = (ctl_bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_HALT;
                    OP_JAL:    w_state_nxt = S_JAL;
                    default:   w_state_nxt = S_HALT;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_state_nxt = ctl_bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (ctl_bus.mem_ready) w_state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (ctl_bus.mem_ready) w_state_nxt = S_FETCH;
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = w_alu_op;
                w_state_nxt   = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_op;
                w_state_nxt   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                // Compare via SUB; target was computed into ALUOut during DECODE.
                w_alu_src_a   = 2'b10;
                w_alu_control = ALU_SUB;
                w_pc_write    = ctl_bus.funct3[0] ? ~ctl_bus.zero : ctl_bus.zero;
                w_state_nxt   = S_FETCH;
            end
            S_JAL: begin
                // Jump to ALUOut while the ALU forms OldPC+4 for the link write.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_state_nxt = S_ALUWB;
            end
            S_HALT: begin
                w_illegal   = 1'b1;
                w_state_nxt = S_HALT;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Reset forces every output low immediately, including an in-flight store strobe.
    assign ctl_bus.mem_req     = w_mem_req   & ~reset;
    assign ctl_bus.mem_write   = w_mem_write & ~reset;
    assign ctl_bus.adr_src     = w_adr_src   & ~reset;
    assign ctl_bus.ir_write    = w_ir_write  & ~reset;
    assign ctl_bus.pc_write    = w_pc_write  & ~reset;
    assign ctl_bus.reg_write   = w_reg_write & ~reset;
    assign ctl_bus.alu_src_a   = w_alu_src_a   & {2{~reset}};
    assign ctl_bus.alu_src_b   = w_alu_src_b   & {2{~reset}};
    assign ctl_bus.result_src  = w_result_src  & {2{~reset}};
    assign ctl_bus.alu_control = w_alu_control & {4{~reset}};
    assign ctl_bus.illegal     = w_illegal   & ~reset;

`ifdef MC_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    // Cycle and retire counters; an instruction retires when the FSM re-enters FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt   <= 32'd0;
            r_instret_cnt <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_state_nxt == S_FETCH && r_state != S_FETCH)
                r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign ctl_bus.cycle_cnt   = r_cycle_cnt;
    assign ctl_bus.instret_cnt = r_instret_cnt;
`else
    assign ctl_bus.cycle_cnt   = 32'h0;
    assign ctl_bus.instret_cnt = 32'h0;
`endif

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM that sequences a multicycle build of the RV32I subset datapath: ADDI, ADD/SUB/logic/shift/SLT, LW, SW, BEQ/BNE, JAL. It sits beside the datapath and drives its mux selects, write enables and `alu_control`, using the ALU encoding the datapath already decodes. It also owns a request/ready handshake to a shared instruction/data memory, so fetch and load/store can stall.

## Interface
- No parameters.
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `opcode`  in  7  IR[6:0]
- `funct3`  in  3  IR[14:12]
- `funct7`  in  7  IR[31:25]
- `zero`  in  1  ALU result == 0
- `mem_ready`  in  1  memory accepts/returns this cycle
- `mem_req`  out  1  memory access active
- `mem_write`  out  1  store strobe
- `adr_src`  out  1  0 = PC, 1 = Result
- `ir_write`  out  1  latch IR and OldPC
- `pc_write`  out  1  PC <= Result
- `reg_write`  out  1  register file write
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 A
- `alu_src_b`  out  2  00 WriteData, 01 ImmExt, 10 const 4
- `result_src`  out  2  00 ALUOut, 01 Data, 10 ALUResult
- `alu_control`  out  4  0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 SLL, 0101 SRL, 0100 XOR, 0111 SLT
- `illegal`  out  1  sticky illegal-instruction flag
- `cycle_cnt`  out  32  perf counter
- `instret_cnt`  out  32  perf counter

## Operation
- States, 4-bit: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT.
- All outputs default to 0 / ADD unless listed.
- FETCH: mem_req=1, adr_src=0, srcA=00, srcB=10, ADD, result_src=10.
  - ir_write and pc_write are asserted only while mem_ready=1; then go to DECODE. Otherwise hold.
- DECODE: srcA=01, srcB=01, ADD (branch/jump target goes to ALUOut). Dispatch on opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH, only if funct3 is 000 or 001
  - 1101111 → JAL
  - anything else → HALT
- MEMADR: srcA=10, srcB=01, ADD. Go to MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Go to MEMWB on mem_ready.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Go to FETCH on mem_ready.
- EXECR: srcA=10, srcB=00 → ALUWB. EXECI: srcA=10, srcB=01 → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- ALU decode for EXECR/EXECI, by funct3:
  - 000: ADD, or SUB only when EXECR and funct7[5]=1
  - 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND
  - 011 (SLTU): DECODE sends it to HALT
- BRANCH: srcA=10, srcB=00, SUB, result_src=00. pc_write=zero for funct3=000, ~zero for 001 → FETCH.
- JAL: srcA=01, srcB=10, ADD, result_src=00, pc_write=1 → ALUWB, which writes OldPC+4.
- HALT: all enables 0, illegal=1. Leave only on reset.

## Timing
- Next state is registered; outputs decode combinationally from state plus zero/mem_ready/funct fields.
- While reset is high and after release: state=FETCH. Every output is forced to 0 during reset, including mem_req, illegal and the counters. FETCH outputs appear on the first cycle after release.
- Latency with mem_ready=1 every cycle:
  - LW 5 cycles; SW 4; R/I-ALU 4; BEQ/BNE 3; JAL 4.
  - Each cycle mem_ready is low adds one cycle per memory state.
- Handshake: mem_req and the address/strobe selects hold steady until mem_ready. mem_ready is ignored when mem_req=0.
- Reset mid-store drops mem_write in the same cycle (asynchronous). Writes already committed are not rolled back.
- zero is sampled only in BRANCH.

## Configuration
- `MC_PERF_EN` defined:
  - cycle_cnt increments every cycle outside reset.
  - instret_cnt increments on every transition into FETCH; HALT never retires.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: both counters are tied to 32'h0 and no counter flops are synthesized.

## Test plan
- Reset, mem_ready=1, opcode=0010011, funct3=000 → FETCH, DECODE, EXECI (alu_control=0010, srcB=01), ALUWB (reg_write=1), FETCH. Four cycles.
- LW (0000011) with mem_ready low for 2 cycles in MEMREAD → mem_req/adr_src=1 held for 3 cycles; MEMWB result_src=01; total 7 cycles.
- BEQ with zero=1 → pc_write=1 in BRANCH, alu_control=0110. BNE (funct3=001) with zero=1 → pc_write=0.
- R-type, funct3=000, funct7=0100000 → SUB. Same encoding as I-type → ADD.
- opcode=0110111 → HALT, illegal=1, no further mem_req. Reset then returns to FETCH with illegal=0.
- `MC_PERF_EN`: 3 ADDIs with mem_ready=1 → instret_cnt=3, cycle_cnt=12. Without the macro, both read 0.
